// File: rtl/route_compute_pipe.sv
// Parallel BLESS route computation: per-channel productive-direction matrix,
// age update and illegal-destination flag, registered with one cycle of latency.
module route_compute_lane #(
    parameter  int COORD_W = 2,
    parameter  int AGE_W   = 4,
    parameter  int TORUS   = 1,
    localparam int FLIT_W  = 1 + 4*COORD_W + AGE_W
) (
    input  logic [FLIT_W-1:0]  flit_i,
    input  logic [COORD_W-1:0] my_x_i,
    input  logic [COORD_W-1:0] my_y_i,
    input  logic [COORD_W-1:0] max_x_i,
    input  logic [COORD_W-1:0] max_y_i,
    output logic [FLIT_W-1:0]  flit_o,
    output logic [4:0]         rmat_o,
    output logic               err_o
);
    logic               vld;
    logic [COORD_W-1:0] dst_x, dst_y;
    logic [AGE_W-1:0]   age;
    logic [1:0]         xd, yd;

    assign vld   = flit_i[FLIT_W-1];
    assign dst_x = flit_i[AGE_W+COORD_W +: COORD_W];
    assign dst_y = flit_i[AGE_W +: COORD_W];
    assign age   = flit_i[AGE_W-1:0];

    // Returns {plus, minus}: plus = increasing coordinate (E/S), minus = decreasing (W/N).
    function automatic logic [1:0] axis_dir(input logic [COORD_W-1:0] dst,
                                            input logic [COORD_W-1:0] my,
                                            input logic [COORD_W-1:0] mx);
        logic [COORD_W:0] r, fwd, bwd;
        logic [1:0]       d;
        r   = {1'b0, mx} + (COORD_W+1)'(1);
        fwd = {1'b0, dst} - {1'b0, my};
        if (dst < my) fwd = fwd + r;
        bwd = r - fwd;
        d   = 2'b00;
        if (TORUS != 0) begin
            if (fwd == '0)      d = 2'b00;
            else if (fwd < bwd) d = 2'b10;
            else if (fwd > bwd) d = 2'b01;
            else                d = 2'b11;
        end else begin
            if (dst > my)       d = 2'b10;
            else if (dst < my)  d = 2'b01;
        end
        return d;
    endfunction

    always_comb begin
        flit_o = flit_i;
        rmat_o = '0;
        err_o  = 1'b0;
        xd     = axis_dir(dst_x, my_x_i, max_x_i);
        yd     = axis_dir(dst_y, my_y_i, max_y_i);
        if (vld) begin
            flit_o[AGE_W-1:0] = (&age) ? age : age + AGE_W'(1);
            err_o = (dst_x > max_x_i) || (dst_y > max_y_i);
            if (!err_o) begin
                if (dst_x == my_x_i && dst_y == my_y_i) rmat_o[4] = 1'b1;
                else rmat_o[3:0] = {xd[0], xd[1], yd[1], yd[0]};
            end
        end
    end
endmodule

module route_compute_pipe #(
    parameter  int COORD_W = 2,
    parameter  int AGE_W   = 4,
    parameter  int N_CH    = 4,
    parameter  int TORUS   = 1,
    localparam int FLIT_W  = 1 + 4*COORD_W + AGE_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    input  logic [COORD_W-1:0]     my_x,
    input  logic [COORD_W-1:0]     my_y,
    input  logic [COORD_W-1:0]     max_x,
    input  logic [COORD_W-1:0]     max_y,
    input  logic [N_CH*FLIT_W-1:0] flit_in,
    output logic [N_CH*FLIT_W-1:0] flit_out,
    output logic [N_CH*5-1:0]      rmatrix,
    output logic [N_CH-1:0]        err,
    output logic [15:0]            flit_count
);
    logic [N_CH-1:0][FLIT_W-1:0] flit_in_a, flit_d, flit_q;
    logic [N_CH-1:0][4:0]        rmat_d, rmat_q;
    logic [N_CH-1:0]             err_d, err_q;
    logic [15:0]                 cnt_d, cnt_q;
    logic [16:0]                 cnt_sum;

    assign flit_in_a = flit_in;

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        route_compute_lane #(
            .COORD_W(COORD_W), .AGE_W(AGE_W), .TORUS(TORUS)
        ) u_lane (
            .flit_i  (flit_in_a[c]),
            .my_x_i  (my_x),
            .my_y_i  (my_y),
            .max_x_i (max_x),
            .max_y_i (max_y),
            .flit_o  (flit_d[c]),
            .rmat_o  (rmat_d[c]),
            .err_o   (err_d[c])
        );
    end

    // One extra bit catches overflow so the counter can clamp instead of wrapping.
    always_comb begin
        cnt_sum = {1'b0, cnt_q};
        for (int c = 0; c < N_CH; c++) cnt_sum = cnt_sum + 17'(flit_in_a[c][FLIT_W-1]);
        cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            flit_q <= '0;
            rmat_q <= '0;
            err_q  <= '0;
            cnt_q  <= '0;
        end else if (!stall) begin
            flit_q <= flit_d;
            rmat_q <= rmat_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign flit_out   = flit_q;
    assign rmatrix    = rmat_q;
    assign err        = err_q;
    assign flit_count = cnt_q;
endmodule
